// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the bus, deframes 11-bit frames and buffers scan codes.
// Optional mid-frame watchdog abort is enabled by defining PS2_TIMEOUT_EN.
module ps2_rx_fifo #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rd_ready,
   output logic                          rd_valid,
   output logic [7:0]                    rd_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clr_flags
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {StIdle, StRecv} state_e;

   state_e          r_state;
   logic [3:0]      r_bit_cnt;
   logic [8:0]      r_shift;
   logic [2:0]      r_clk_sync;
   logic [1:0]      r_dat_sync;
   logic            r_frame_err;
   logic            r_overflow;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_fall;
   logic            w_bit;
   logic            w_done;
   logic            w_good;
   logic            w_bad;
   logic            w_abort;
   logic            w_full;
   logic            w_rd_valid;
   logic            w_push;
   logic            w_pop;

   // Chains reset to ones so a reset never manufactures a falling edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
      end
   end

   assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_bit  = r_dat_sync[1];

   // Stop bit arrives at bit_cnt 10; shift then holds {parity, data[7:0]}.
   assign w_done = (r_state == StRecv) && w_fall && (r_bit_cnt == 4'd10) && !w_abort;
   assign w_good = w_done && w_bit && (^r_shift);
   assign w_bad  = (w_done && !w_good) || w_abort;

`ifdef PS2_TIMEOUT_EN
   localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
   logic [15:0] r_wdog;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wdog <= '0;
      end else if (r_state == StIdle || w_fall) begin
         r_wdog <= '0;
      end else if (r_wdog != TimeoutLimit) begin
         r_wdog <= r_wdog + 16'd1;
      end
   end

   assign w_abort = (r_state == StRecv) && (r_wdog == TimeoutLimit);
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_bad;
         if (w_abort) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
         end else if (w_fall) begin
            unique case (r_state)
               StIdle: begin
                  if (!w_bit) begin
                     r_state   <= StRecv;
                     r_bit_cnt <= 4'd1;
                  end
               end
               StRecv: begin
                  if (r_bit_cnt == 4'd10) begin
                     r_state   <= StIdle;
                     r_bit_cnt <= '0;
                  end else begin
                     r_shift   <= {w_bit, r_shift[8:1]};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               default: begin
                  r_state   <= StIdle;
                  r_bit_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_rd_valid = (r_count != '0);
   assign w_pop      = w_rd_valid && rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push     = w_good && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_shift[7:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         if (w_good && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end else if (clr_flags) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign rd_valid   = w_rd_valid;
   assign rd_data    = w_rd_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign frame_err  = r_frame_err;

endmodule
